adder16_rr_scheduler: RTL and testbench
=======================================

Name: adder16_rr_scheduler

Overview:
- Time-shares one external 16-bit ripple-carry adder among NREQ requesters.
- Arbitration is round-robin. Each accepted operation's operands are registered onto the adder inputs.
- The block waits SETTLE cycles for the ripple carry to resolve, then registers sum and carry-out and returns them tagged with the requester id.
- It sits between the requesting datapath units and the shared 16-bit full-adder chain.

Parameters:
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ).
- SETTLE, 2, cycles the adder inputs are held stable before the result is captured (>=1; 0 is illegal, flagged at elaboration).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request, level.
- op_a  in  16*NREQ  operand A, requester i at bits [16i+15:16i].
- op_b  in  16*NREQ  operand B, same packing.
- op_cin  in  NREQ  carry-in per requester.
- gnt  out  NREQ  one-hot acceptance pulse, registered.
- add_a  out  16  to shared adder input a.
- add_b  out  16  to shared adder input b.
- add_cin  out  1  to shared adder carry-in.
- add_sum  in  16  from shared adder sum.
- add_cout  in  1  from shared adder carry-out.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  IDW  requester index of the result.
- res_sum  out  16  captured sum.
- res_cout  out  1  captured carry-out.
- busy  out  1  high while an operation is in flight.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - state=IDLE; gnt, add_a, add_b, add_cin, res_valid, res_id, res_sum, res_cout, busy all 0.
  - Round-robin pointer ptr=0; settle counter cnt=0.
- FSM states IDLE and SETTLE. req is sampled only in IDLE.
- IDLE, req==0: hold state; gnt=0.
- IDLE, req!=0, at edge E0:
  - winner w = first set bit scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - add_a/add_b/add_cin <= operands of w.
  - gnt <= onehot(w) for exactly one cycle.
  - cur_id <= w; ptr <= (w+1) mod NREQ.
  - cnt <= SETTLE-1; state <= SETTLE; busy <= 1.
- SETTLE:
  - cnt decrements each edge.
  - At the edge where cnt==0 (edge E_SETTLE): res_sum <= add_sum, res_cout <= add_cout, res_id <= cur_id, res_valid <= 1 for one cycle; state <= IDLE; busy <= 0.
- Latency and throughput:
  - res_valid is high in the cycle following edge E_SETTLE, i.e. SETTLE edges after capture.
  - The next capture can occur at E_SETTLE+1, so one operation per SETTLE+1 cycles.
  - That next capture may coincide with res_valid high.
- Hold behaviour:
  - add_a/add_b/add_cin hold their last values between operations and are not cleared.
  - res_sum/res_cout/res_id hold until the next capture.
  - res_valid is a strobe only.
- Requester protocol:
  - Hold req, operands and cin stable until gnt[i] is seen.
  - Deassert req the cycle after gnt[i], unless a new operation is wanted.
  - Operands are captured at E0, so changes after E0 do not affect the in-flight operation.
  - A req still high on return to IDLE is treated as a new request.
- Width rule: no internal arithmetic; the 17-bit result is {add_cout, add_sum} as produced by the adder.
- Reset mid-SETTLE:
  - The operation is discarded; no res_valid is issued.
  - All outputs return to reset values and ptr=0.
- Requests arriving during SETTLE wait and are not lost while held. There is no starvation: each waiting requester is served within NREQ operations.

Test Plan:
1. Assert rst mid-simulation with random inputs -> all outputs 0 immediately (async), busy=0; after release with req=0, outputs stay 0.
2. NREQ=4, SETTLE=2, bench adder = real 16-bit ripple adder:
   - req[0] with a=0x1234, b=0x4321, cin=0 -> gnt=0001 one cycle after E0.
   - res_valid 2 edges after E0 with res_sum=0x5555, res_cout=0, res_id=0.
3. Carry extremes on req[2]:
   - 0xFFFF+0x0001, cin=0 -> sum 0x0000, cout 1.
   - 0xFFFF+0xFFFF, cin=1 -> sum 0xFFFF, cout 1.
   - Both with res_id=2.
4. Fairness:
   - req=1111, each requester held until its own gnt -> grant order 0,1,2,3.
   - Then, with ptr=0 after 3, req=1010 -> grants 1 then 3.
   - Check back-to-back spacing is exactly SETTLE+1 cycles.
5. Assert rst one cycle into SETTLE for req[1] -> no res_valid. After release, req=0110 -> req[1] granted first (ptr reset to 0).
6. SETTLE=4 with a bench adder whose outputs change 3 cycles after input change:
   - res_valid exactly 4 edges after capture, with the correct settled sum.
   - Operands changed by the requester after gnt do not alter the result.

Source files
------------

// File: rtl/adder16_rr_scheduler.sv
// adder16_rr_scheduler: round-robin time-sharing of one external 16-bit
// ripple adder, holding its inputs for a fixed carry-settle window.
module adder16_rr_scheduler #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   op_a,
    input  logic [16*NREQ-1:0]   op_b,
    input  logic [NREQ-1:0]      op_cin,
    output logic [NREQ-1:0]      gnt,
    output logic [15:0]          add_a,
    output logic [15:0]          add_b,
    output logic                 add_cin,
    input  logic [15:0]          add_sum,
    input  logic                 add_cout,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [15:0]          res_sum,
    output logic                 res_cout,
    output logic                 busy
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("adder16_rr_scheduler: SETTLE must be >= 1");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("adder16_rr_scheduler: NREQ must be in 2..8");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] win;
    logic [CW-1:0]  cnt;
    logic           start;
    logic           done;

    logic [15:0]    a_arr [NREQ];
    logic [15:0]    b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = op_a[16*i +: 16];
        assign b_arr[i] = op_b[16*i +: 16];
    end

    // Scan downward so the lowest offset from ptr is written last and wins.
    always_comb begin
        int j;
        j   = 0;
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[IDW'(j)]) begin
                win = IDW'(j);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    start     = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            busy      <= 1'b0;
            ptr       <= '0;
            cur_id    <= '0;
            cnt       <= '0;
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            if (start) begin
                add_a   <= a_arr[win];
                add_b   <= b_arr[win];
                add_cin <= op_cin[win];
                gnt     <= NREQ'(1) << win;
                cur_id  <= win;
                ptr     <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                cnt     <= CW'(SETTLE - 1);
                busy    <= 1'b1;
            end else if (done) begin
                res_sum   <= add_sum;
                res_cout  <= add_cout;
                res_id    <= cur_id;
                res_valid <= 1'b1;
                busy      <= 1'b0;
            end else if (state == S_SETTLE) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder16_rr_scheduler.sv
// tb_adder16_rr_scheduler: directed checks of arbitration, settle timing
// and reset behaviour against a combinational and a slow bench adder.
module tb_adder16_rr_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // SETTLE=2 instance, ideal adder
    logic [3:0]  req, op_cin, gnt;
    logic [63:0] op_a, op_b;
    logic [15:0] add_a, add_b, add_sum, res_sum;
    logic        add_cin, add_cout, res_valid, res_cout, busy;
    logic [1:0]  res_id;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    adder16_rr_scheduler #(.NREQ(4), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .op_cin(op_cin), .gnt(gnt), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
        .res_cout(res_cout), .busy(busy)
    );

    // SETTLE=4 instance, adder output lags its inputs by 3 cycles
    logic [3:0]  req4, cin4, gnt4;
    logic [63:0] opa4, opb4;
    logic [15:0] a4, b4, sum4, rsum4;
    logic        ci4, co4, rv4, rco4, busy4;
    logic [1:0]  rid4;
    logic [16:0] d0, d1, d2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            d0 <= {1'b0, a4} + {1'b0, b4} + {16'd0, ci4};
            d1 <= d0;
            d2 <= d1;
        end
    end
    assign {co4, sum4} = d2;

    adder16_rr_scheduler #(.NREQ(4), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req4), .op_a(opa4), .op_b(opb4),
        .op_cin(cin4), .gnt(gnt4), .add_a(a4), .add_b(b4),
        .add_cin(ci4), .add_sum(sum4), .add_cout(co4),
        .res_valid(rv4), .res_id(rid4), .res_sum(rsum4),
        .res_cout(rco4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {6'd0, gnt, add_a, add_b, add_cin, res_valid, res_id,
                res_sum, res_cout, busy};
    endfunction

    function automatic logic [63:0] outs4();
        return {6'd0, gnt4, a4, b4, ci4, rv4, rid4, rsum4, rco4, busy4};
    endfunction

    task automatic set_op(input int i, input logic [15:0] a,
                          input logic [15:0] b, input logic c);
        op_a[16*i +: 16] = a;
        op_b[16*i +: 16] = b;
        op_cin[i]        = c;
    endtask

    task automatic set_op4(input int i, input logic [15:0] a,
                           input logic [15:0] b, input logic c);
        opa4[16*i +: 16] = a;
        opb4[16*i +: 16] = b;
        cin4[i]          = c;
    endtask

    // Returns gnt=0 on timeout, which the caller's compare then flags.
    task automatic wait_gnt(output logic [3:0] g, output int at);
        g  = '0;
        at = cyc;
        for (int k = 0; k < 20 && g == 4'b0000; k++) begin
            tick();
            if (gnt != 4'b0000) begin
                g  = gnt;
                at = cyc;
            end
        end
    endtask

    task automatic run_op(input string tag, input int i,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] es,
                          input logic ec);
        set_op(i, a, b, c);
        req = 4'b0001 << i;
        tick();
        check({tag, "_gnt"}, gnt, 4'b0001 << i);
        req = '0;
        tick();
        check({tag, "_early"}, res_valid, 1'b0);
        tick();
        check({tag, "_valid"}, res_valid, 1'b1);
        check({tag, "_sum"}, res_sum, es);
        check({tag, "_cout"}, res_cout, ec);
        check({tag, "_id"}, res_id, i[1:0]);
        tick();
    endtask

    logic [3:0] g;
    int at, prev;

    initial begin
        rst = 1'b1;
        req = '0; op_a = '0; op_b = '0; op_cin = '0;
        req4 = '0; opa4 = '0; opb4 = '0; cin4 = '0;
        tick();
        tick();
        check("reset_outs", outs(), 64'd0);
        check("reset_outs4", outs4(), 64'd0);
        rst = 1'b0;
        tick();

        // single op, requester 0
        set_op(0, 16'h1234, 16'h4321, 1'b0);
        req = 4'b0001;
        tick();
        check("t2_gnt", gnt, 4'b0001);
        check("t2_busy", busy, 1'b1);
        check("t2_add_a", add_a, 16'h1234);
        req = '0;
        tick();
        check("t2_gnt_pulse", gnt, 4'b0000);
        check("t2_early", res_valid, 1'b0);
        tick();
        check("t2_valid", res_valid, 1'b1);
        check("t2_sum", res_sum, 16'h5555);
        check("t2_cout", res_cout, 1'b0);
        check("t2_id", res_id, 2'd0);
        check("t2_idle", busy, 1'b0);
        tick();
        check("t2_strobe", res_valid, 1'b0);
        check("t2_hold", res_sum, 16'h5555);

        // carry extremes
        run_op("t3a", 2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("t3b", 2, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // async reset mid-operation with random inputs
        op_a   = {$urandom, $urandom};
        op_b   = {$urandom, $urandom};
        op_cin = 4'($urandom);
        req    = 4'($urandom_range(1, 15));
        tick();
        check("t1_busy_pre", busy, 1'b1);
        #2 rst = 1'b1;
        #1 check("t1_async", outs(), 64'd0);
        tick();
        tick();
        req = '0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("t1_after", outs(), 64'd0);

        // fairness: all four, then 1010 from ptr=0
        for (int i = 0; i < 4; i++) set_op(i, 16'h0100 * 16'(i), 16'h0001, 1'b0);
        req  = 4'b1111;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g, at);
            check($sformatf("t4_order%0d", i), g, 4'b0001 << i);
            if (i > 0) check($sformatf("t4_space%0d", i), at - prev, 3);
            prev   = at;
            req[i] = 1'b0;
        end
        req = 4'b1010;
        wait_gnt(g, at);
        check("t4_b_first", g, 4'b0010);
        check("t4_b_space1", at - prev, 3);
        prev   = at;
        req[1] = 1'b0;
        wait_gnt(g, at);
        check("t4_b_second", g, 4'b1000);
        check("t4_b_space2", at - prev, 3);
        req = '0;
        for (int k = 0; k < 3; k++) tick();

        // reset one cycle into SETTLE discards the op and clears ptr
        set_op(1, 16'h0F0F, 16'h0101, 1'b1);
        req = 4'b0010;
        tick();
        check("t5_gnt", gnt, 4'b0010);
        req = '0;
        tick();
        #2 rst = 1'b1;
        #1 check("t5_async", outs(), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("t5_noval%0d", k), res_valid, 1'b0);
        end
        rst = 1'b0;
        tick();
        check("t5_noval_rel", res_valid, 1'b0);
        req = 4'b0110;
        wait_gnt(g, at);
        check("t5_ptr0", g, 4'b0010);
        req = '0;
        for (int k = 0; k < 4; k++) tick();

        // SETTLE=4 with a slow adder; operands scrambled after gnt
        set_op4(0, 16'h8001, 16'h7FFF, 1'b1);
        req4 = 4'b0001;
        tick();
        check("t6a_gnt", gnt4, 4'b0001);
        req4 = '0;
        set_op4(0, 16'h0000, 16'h0000, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check($sformatf("t6a_early%0d", k), rv4, 1'b0);
        end
        tick();
        check("t6a_valid", rv4, 1'b1);
        check("t6a_sum", rsum4, 16'h0001);
        check("t6a_cout", rco4, 1'b1);
        check("t6a_id", rid4, 2'd0);

        set_op4(3, 16'h00FF, 16'h0F01, 1'b0);
        req4 = 4'b1000;
        tick();
        check("t6b_gnt", gnt4, 4'b1000);
        req4 = '0;
        set_op4(3, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check($sformatf("t6b_early%0d", k), rv4, 1'b0);
        end
        tick();
        check("t6b_valid", rv4, 1'b1);
        check("t6b_sum", rsum4, 16'h1000);
        check("t6b_cout", rco4, 1'b0);
        check("t6b_id", rid4, 2'd3);
        tick();
        check("t6b_strobe", rv4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
